// File: rtl/ldl_fifo_ws_v2_pkg.sv
// rtl/ldl_fifo_ws_v2_pkg.sv - shared Gray-code and depth helpers for the LDL FIFO pointer blocks
package ldl_fifo_pkg;

    // Number of RAM entries for a given address width
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Binary to reflected Gray; callers truncate to their pointer width
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray back to binary; used by the read-side block
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ldl_fifo_ws_v2_if.sv
// rtl/ldl_fifo_ws_v2_if.sv - producer-facing bus of the LDL FIFO write-side controller
interface ldl_fifo_ws_v2_if #(
    parameter int AW = 8,
    parameter int WN = 4
);
    localparam int NW = $clog2(WN + 1);

    logic          we;
    logic [NW-1:0] wn;
    logic [AW:0]   afull_th;
    logic          ovf_clr;
    logic          hwm_clr;
    logic [AW:0]   r_pt;
    logic [AW-1:0] wa;
    logic          mw;
    logic [AW:0]   w_pt;
    logic [AW:0]   w_pt_gray;
    logic [AW:0]   wcnt;
    logic [AW:0]   free;
    logic          full;
    logic          afull;
    logic          ovf;
    logic [AW:0]   hwm;

    modport master (
        output we, wn, afull_th, ovf_clr, hwm_clr, r_pt,
        input  wa, mw, w_pt, w_pt_gray, wcnt, free, full, afull, ovf, hwm
    );

    modport slave (
        input  we, wn, afull_th, ovf_clr, hwm_clr, r_pt,
        output wa, mw, w_pt, w_pt_gray, wcnt, free, full, afull, ovf, hwm
    );

endinterface

// File: rtl/ldl_bin2gray_reg.sv
// rtl/ldl_bin2gray_reg.sv - registered binary-to-Gray converter for pointer export across clocks
module ldl_bin2gray_reg
    import ldl_fifo_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    logic [W-1:0] gray_q;
    logic [W-1:0] gray_d;

    assign gray_d = W'(bin2gray(32'(bin_i)));
    assign gray_o = gray_q;

    // Register the Gray value so the exported bus changes only at the clock edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

endmodule

// File: rtl/ldl_fifo_ws_v2.sv
// rtl/ldl_fifo_ws_v2.sv - multi-entry write-side pointer and flag controller for LDL FIFOs
module ldl_fifo_ws_v2
    import ldl_fifo_pkg::*;
#(
    parameter int AW = 8,
    parameter int WN = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ldl_fifo_ws_v2_if.slave     bus
);

    localparam int          NW    = $clog2(WN + 1);
    localparam logic [AW:0] DEPTH = (AW+1)'(depth_of(AW));
    localparam logic [NW-1:0] WN_L = NW'(WN);

    logic [AW:0] w_pt_q;
    logic [AW:0] w_pt_d;
    logic        ovf_q;
    logic        ovf_d;
    logic [AW:0] hwm_q;
    logic [AW:0] hwm_d;
    logic [AW:0] gray_q;

    logic [AW:0] wn_ext;
    logic [AW:0] wcnt;
    logic [AW:0] free;
    logic        req;
    logic        legal;
    logic        acc;
    logic        rej;

    // Occupancy and flags come straight from the two pointers; a read landing this
    // cycle is only seen next cycle, so free space is conservative
    assign wn_ext = (AW+1)'(bus.wn);
    assign wcnt   = w_pt_q - bus.r_pt;
    assign free   = DEPTH - wcnt;

    // A beat is all-or-nothing; reset aborts any beat in flight
    assign req   = rst_ni & bus.we & (bus.wn != '0);
    assign legal = (bus.wn <= WN_L);
    assign acc   = req & legal & (wn_ext <= free);
    assign rej   = req & ~(legal & (wn_ext <= free));

    // Next-state values for pointer, sticky overflow and high-water mark
    always_comb begin
        w_pt_d = acc ? (w_pt_q + wn_ext) : w_pt_q;
        ovf_d  = rej ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
        hwm_d  = bus.hwm_clr ? wcnt : ((wcnt > hwm_q) ? wcnt : hwm_q);
    end

    // Pointer, overflow and high-water state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_pt_q <= '0;
            ovf_q  <= 1'b0;
            hwm_q  <= '0;
        end else begin
            w_pt_q <= w_pt_d;
            ovf_q  <= ovf_d;
            hwm_q  <= hwm_d;
        end
    end

    // Gray copy is built from the next pointer so it never lags the binary one
    ldl_bin2gray_reg #(
        .W (AW + 1)
    ) u_gray (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bin_i  (w_pt_d),
        .gray_o (gray_q)
    );

    assign bus.wa        = w_pt_q[AW-1:0];
    assign bus.mw        = acc;
    assign bus.w_pt      = w_pt_q;
    assign bus.w_pt_gray = gray_q;
    assign bus.wcnt      = wcnt;
    assign bus.free      = free;
    assign bus.full      = (wcnt == DEPTH);
    assign bus.afull     = (wcnt >= bus.afull_th);
    assign bus.ovf       = ovf_q;
    assign bus.hwm       = hwm_q;

`ifndef SYNTHESIS
    // Oversized requests and an out-of-range read pointer are producer/integration bugs
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(bus.we && !legal));
            assert (wcnt <= DEPTH);
        end
    end
`endif

endmodule
